sonic_obstacle_filter: RTL and testbench

- Sits between the ultrasonic distance counter (20-bit distance in 0.1 mm units plus a per-measurement valid pulse) and the motor-direction mux in the car top level.
- Smooths distance with a 2^AVG_LOG2-sample moving average and applies confirm-count hysteresis before asserting `stop`.
- Fail-safe: forces `stop` when the window is not yet full, or when measurements cease for TIMEOUT_CYC cycles.

---
 rtl/sonic_obstacle_filter.sv | 170 +++++++++++++++++
 tb/tb_sonic_obstacle_filter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sonic_obstacle_filter.sv
// sonic_obstacle_filter
//   Smooths ultrasonic distance samples with a moving average over a
//   2^AVG_LOG2 window and applies confirm-count hysteresis before raising
//   `stop`. Fails safe: `stop` is held while the window is filling, and the
//   block drops into a timeout state if samples stop arriving.
//
// Ports
//   clk        : system clock
//   rst        : synchronous reset, active low
//   dist_in    : raw distance sample (0.1 mm units)
//   dist_valid : one-cycle strobe qualifying dist_in
//   stop       : obstacle / fail-safe stop request (decoded from state register)
//   avg_dist   : registered window average
//   avg_valid  : one-cycle strobe, avg_dist refreshed from a full window
//   timeout    : high while in the timeout state
module sonic_obstacle_filter #(
  parameter int DIST_W      = 20,
  parameter int AVG_LOG2    = 2,
  parameter int NEAR_TH     = 4000,
  parameter int FAR_TH      = 4500,
  parameter int CONFIRM     = 2,
  parameter int TIMEOUT_CYC = 15_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIST_W-1:0] dist_in,
  input  logic              dist_valid,
  output logic              stop,
  output logic [DIST_W-1:0] avg_dist,
  output logic              avg_valid,
  output logic              timeout
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = DIST_W + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;
  localparam int CONF_W = $clog2(CONFIRM + 1);
  localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    S_FILL,
    S_CLEAR,
    S_NEAR,
    S_TIMEOUT
  } state_t;

  state_t              state_reg;
  logic [DIST_W-1:0]   window_reg [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr_reg;
  logic [SUM_W-1:0]    sum_reg;
  logic [FILL_W-1:0]   fill_cnt_reg;
  logic [CONF_W-1:0]   confirm_reg;
  logic [TO_W-1:0]     to_cnt_reg;
  logic [DIST_W-1:0]   avg_dist_reg;
  logic                avg_valid_reg;

  logic [SUM_W-1:0]    sum_next;
  logic [DIST_W-1:0]   avg_next;
  logic [CONF_W-1:0]   confirm_inc;
  logic                confirm_done;
  logic                is_near;
  logic                is_far;
  logic                to_terminal;
  logic                to_fire;
  logic                fill_last;

  // Unfilled / flushed entries hold zero, so the oldest entry can always be
  // subtracted unconditionally. The sum is wide enough that it never wraps,
  // and it is always >= the oldest entry, so the subtraction cannot underflow.
  always_comb begin
    sum_next     = sum_reg + SUM_W'(dist_in) - SUM_W'(window_reg[wr_ptr_reg]);
    avg_next     = sum_next[SUM_W-1:AVG_LOG2];
    is_near      = (avg_next < DIST_W'(NEAR_TH));
    is_far       = (avg_next >= DIST_W'(FAR_TH));
    confirm_inc  = confirm_reg + 1'b1;
    confirm_done = (confirm_inc == CONF_W'(CONFIRM));
    to_terminal  = (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));
    // A sample arriving on the terminal count keeps the filter alive.
    to_fire      = to_terminal && !dist_valid;
    fill_last    = (fill_cnt_reg == FILL_W'(DEPTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= S_FILL;
      wr_ptr_reg    <= '0;
      sum_reg       <= '0;
      fill_cnt_reg  <= '0;
      confirm_reg   <= '0;
      to_cnt_reg    <= '0;
      avg_dist_reg  <= '0;
      avg_valid_reg <= 1'b0;
      for (int i = 0; i < DEPTH; i++) window_reg[i] <= '0;
    end else begin
      avg_valid_reg <= 1'b0;

      if (dist_valid)        to_cnt_reg <= '0;
      else if (!to_terminal) to_cnt_reg <= to_cnt_reg + 1'b1;

      if (to_fire) begin
        // Flush history so the first sample after recovery starts a new window.
        state_reg    <= S_TIMEOUT;
        wr_ptr_reg   <= '0;
        sum_reg      <= '0;
        fill_cnt_reg <= '0;
        confirm_reg  <= '0;
        for (int i = 0; i < DEPTH; i++) window_reg[i] <= '0;
      end else if (dist_valid) begin
        window_reg[wr_ptr_reg] <= dist_in;
        wr_ptr_reg             <= wr_ptr_reg + 1'b1;
        sum_reg                <= sum_next;

        case (state_reg)
          // TIMEOUT was flushed on entry, so its first sample behaves as a fill.
          S_FILL, S_TIMEOUT: begin
            confirm_reg <= '0;
            if (fill_last) begin
              fill_cnt_reg  <= FILL_W'(DEPTH);
              avg_valid_reg <= 1'b1;
              avg_dist_reg  <= avg_next;
              state_reg     <= is_near ? S_NEAR : S_CLEAR;
            end else begin
              fill_cnt_reg  <= fill_cnt_reg + 1'b1;
              state_reg     <= S_FILL;
            end
          end

          S_CLEAR: begin
            avg_valid_reg <= 1'b1;
            avg_dist_reg  <= avg_next;
            if (is_near) begin
              if (confirm_done) begin
                state_reg   <= S_NEAR;
                confirm_reg <= '0;
              end else begin
                confirm_reg <= confirm_inc;
              end
            end else begin
              confirm_reg <= '0;
            end
          end

          S_NEAR: begin
            avg_valid_reg <= 1'b1;
            avg_dist_reg  <= avg_next;
            // Averages inside the hysteresis band just reset the streak.
            if (is_far) begin
              if (confirm_done) begin
                state_reg   <= S_CLEAR;
                confirm_reg <= '0;
              end else begin
                confirm_reg <= confirm_inc;
              end
            end else begin
              confirm_reg <= '0;
            end
          end

          default: state_reg <= S_FILL;
        endcase
      end
    end
  end

  assign stop      = (state_reg != S_CLEAR);
  assign timeout   = (state_reg == S_TIMEOUT);
  assign avg_dist  = avg_dist_reg;
  assign avg_valid = avg_valid_reg;

endmodule

// File: tb/tb_sonic_obstacle_filter.sv
// Self-checking bench for sonic_obstacle_filter. Expected responses are queued
// as each sample is driven and checked by a monitor one edge later.
module tb_sonic_obstacle_filter;

  localparam int DW = 20;

  logic          clk;
  logic          rst;
  logic [DW-1:0] dist_in;
  logic          dist_valid;
  logic          stop;
  logic [DW-1:0] avg_dist;
  logic          avg_valid;
  logic          timeout;

  sonic_obstacle_filter #(
    .DIST_W(DW), .AVG_LOG2(2), .NEAR_TH(4000), .FAR_TH(4500),
    .CONFIRM(2), .TIMEOUT_CYC(1000)
  ) dut (
    .clk(clk), .rst(rst), .dist_in(dist_in), .dist_valid(dist_valid),
    .stop(stop), .avg_dist(avg_dist), .avg_valid(avg_valid), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          ev;
    logic [DW-1:0] ea;
    logic          es;
    logic          et;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one sample for one edge and queue what the DUT must show after it.
  task automatic sample(input logic [DW-1:0] d, input logic ev, input logic [DW-1:0] ea,
                        input logic es, input logic et);
    exp_t e;
    e.ev = ev; e.ea = ea; e.es = es; e.et = et;
    exp_q.push_back(e);
    dist_in    = d;
    dist_valid = 1'b1;
    @(negedge clk);
    dist_valid = 1'b0;
    $display("[TB] sample din=%0d -> avg_valid=%0b avg=%0d stop=%0b timeout=%0b",
             d, avg_valid, avg_dist, stop, timeout);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: checks outputs 1 time unit after every rising edge.
  initial begin
    logic dv_s, rst_s;
    exp_t e;
    int   n;
    forever begin
      @(posedge clk);
      dv_s  = dist_valid;
      rst_s = rst;
      #1;
      if (!rst_s) begin
        check_eq("rst_stop", stop, 1);
        check_eq("rst_timeout", timeout, 0);
        check_eq("rst_avg_valid", avg_valid, 0);
        check_eq("rst_avg_dist", avg_dist, 0);
      end else if (dv_s) begin
        n = exp_q.size();
        check_eq("sb_nonempty", (n != 0), 1);
        if (n != 0) begin
          e = exp_q.pop_front();
          check_eq("avg_valid", avg_valid, e.ev);
          if (e.ev) check_eq("avg_dist", avg_dist, e.ea);
          check_eq("stop", stop, e.es);
          check_eq("timeout", timeout, e.et);
        end
      end else begin
        check_eq("idle_avg_valid", avg_valid, 0);
      end
    end
  end

  int ap_avg [5] = '{6750, 5500, 4250, 3000, 3000};
  bit ap_stp [5] = '{0, 0, 0, 0, 1};
  int ra_avg [4] = '{3300, 3600, 3900, 4200};
  int lv_avg [3] = '{4400, 4600, 4800};
  bit lv_stp [3] = '{1, 1, 0};
  int z_avg  [4] = '{6000, 4000, 2000, 0};
  bit z_stp  [4] = '{0, 0, 0, 1};
  int f_avg  [3] = '{2250, 4500, 6750};
  bit f_stp  [3] = '{1, 1, 0};

  initial begin
    rst        = 1'b0;
    dist_valid = 1'b0;
    dist_in    = '0;
    @(negedge clk);
    // Reset held while samples arrive: they must be ignored.
    for (int i = 0; i < 3; i++) begin
      dist_in    = 20'd8000;
      dist_valid = 1'b1;
      @(negedge clk);
    end
    dist_valid = 1'b0;
    rst        = 1'b1;
    idle(2);

    // Fill the window.
    for (int i = 0; i < 3; i++) begin
      sample(20'd8000, 0, 0, 1, 0);
      idle(9);
    end
    sample(20'd8000, 1, 20'd8000, 0, 0);
    idle(9);

    // Approach: stop rises on the second near average.
    for (int i = 0; i < 5; i++) begin
      sample(20'd3000, 1, DW'(ap_avg[i]), ap_stp[i], 0);
      idle(9);
    end

    // Hysteresis band: averages between thresholds never release stop.
    for (int i = 0; i < 4; i++) begin
      sample(20'd4200, 1, DW'(ra_avg[i]), 1, 0);
      idle(3);
    end
    for (int i = 0; i < 10; i++) begin
      sample(20'd4200, 1, 20'd4200, 1, 0);
      idle(3);
    end
    for (int i = 0; i < 3; i++) begin
      sample(20'd5000, 1, DW'(lv_avg[i]), lv_stp[i], 0);
      idle(3);
    end
    sample(20'd5000, 1, 20'd5000, 0, 0);

    // Sample coincident with the terminal count: no timeout.
    idle(999);
    sample(20'd5000, 1, 20'd5000, 0, 0);
    check_eq("near_miss_timeout", timeout, 0);

    // Real timeout after 1000 silent cycles.
    idle(999);
    check_eq("pre_timeout", timeout, 0);
    check_eq("pre_timeout_stop", stop, 0);
    idle(1);
    check_eq("timeout_set", timeout, 1);
    check_eq("timeout_stop", stop, 1);
    idle(20);
    check_eq("timeout_held", timeout, 1);

    // Recovery: timeout clears on the first sample, window refills from empty.
    for (int i = 0; i < 3; i++) begin
      sample(20'd3000, 0, 0, 1, 0);
      idle(5);
    end
    sample(20'd3000, 1, 20'd3000, 1, 0);
    idle(5);

    // NEAR -> CLEAR.
    sample(20'd8000, 1, 20'd4250, 1, 0);
    idle(4);
    sample(20'd8000, 1, 20'd5500, 1, 0);
    idle(4);
    sample(20'd8000, 1, 20'd6750, 0, 0);
    idle(4);
    sample(20'd8000, 1, 20'd8000, 0, 0);
    idle(4);

    // Zero samples; an average exactly at the near threshold is not near.
    for (int i = 0; i < 4; i++) begin
      sample(20'd0, 1, DW'(z_avg[i]), z_stp[i], 0);
      idle(4);
    end
    // An average exactly at the far threshold counts as far.
    for (int i = 0; i < 3; i++) begin
      sample(20'd9000, 1, DW'(f_avg[i]), f_stp[i], 0);
      idle(4);
    end

    // Mid-run reset discards history; refill back-to-back.
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    check_eq("midrst_stop", stop, 1);
    idle(3);
    sample(20'd8000, 0, 0, 1, 0);
    sample(20'd8000, 0, 0, 1, 0);
    sample(20'd8000, 0, 0, 1, 0);
    sample(20'd8000, 1, 20'd8000, 0, 0);
    idle(5);

    check_eq("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
